// File: rtl/seq_divider_32.sv
// Iterative restoring divider producing one quotient bit per clock behind a start/done handshake.
// Define DIV_SIGNED_EN for two's-complement operands; the default build is purely unsigned.
module seq_divider_32 #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   state_t             state;
   state_t             state_next;
   logic [WIDTH-1:0]   rem_q;
   logic [WIDTH-1:0]   quo_q;
   logic [WIDTH-1:0]   dsr_q;
   logic [CNT_W-1:0]   count;
   logic [WIDTH:0]     rem_shift;
   logic [WIDTH-1:0]   rem_step;
   logic [WIDTH-1:0]   quo_step;
   logic [WIDTH-1:0]   dividend_mag;
   logic [WIDTH-1:0]   divisor_mag;
   logic [WIDTH-1:0]   final_q;
   logic [WIDTH-1:0]   final_r;

   assign busy = (state != IDLE);

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (start) state_next = (divisor == '0) ? DONE : RUN;
         RUN:  if (count == LAST_CNT) state_next = DONE;
         DONE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // After a restore the partial remainder is always below the divisor, so only the
   // shifted value needs the extra bit; the stored remainder fits in WIDTH bits.
   always_comb begin
      rem_shift = {rem_q, quo_q[WIDTH-1]};
      if (rem_shift >= {1'b0, dsr_q}) begin
         rem_step = rem_shift[WIDTH-1:0] - dsr_q;
         quo_step = {quo_q[WIDTH-2:0], 1'b1};
      end else begin
         rem_step = rem_shift[WIDTH-1:0];
         quo_step = {quo_q[WIDTH-2:0], 1'b0};
      end
   end

`ifdef DIV_SIGNED_EN
   logic neg_q;
   logic neg_r;

   // Divide magnitudes, then restore signs in the final write: quotient truncates
   // toward zero and the remainder follows the dividend's sign.
   always_comb begin
      dividend_mag = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
      divisor_mag  = divisor[WIDTH-1]  ? (~divisor + 1'b1)  : divisor;
      final_q      = neg_q ? (~quo_step + 1'b1) : quo_step;
      final_r      = neg_r ? (~rem_step + 1'b1) : rem_step;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         neg_q <= 1'b0;
         neg_r <= 1'b0;
      end else if (state == IDLE && start) begin
         neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
         neg_r <= dividend[WIDTH-1];
      end
   end
`else
   assign dividend_mag = dividend;
   assign divisor_mag  = divisor;
   assign final_q      = quo_step;
   assign final_r      = rem_step;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         done        <= 1'b0;
         rem_q       <= '0;
         quo_q       <= '0;
         dsr_q       <= '0;
         count       <= '0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         state <= state_next;
         done  <= (state == DONE);
         case (state)
            IDLE: begin
               if (start) begin
                  quo_q       <= dividend_mag;
                  dsr_q       <= divisor_mag;
                  rem_q       <= '0;
                  count       <= '0;
                  div_by_zero <= 1'b0;
                  // A zero divisor skips the iterations; results are ready at DONE.
                  if (divisor == '0) begin
                     quotient    <= '1;
                     remainder   <= dividend;
                     div_by_zero <= 1'b1;
                  end
               end
            end
            RUN: begin
               rem_q <= rem_step;
               quo_q <= quo_step;
               count <= count + 1'b1;
               if (count == LAST_CNT) begin
                  quotient  <= final_q;
                  remainder <= final_r;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_divider_32.sv
// Directed self-checking bench for seq_divider_32 with hand-computed expected results.
// Signed vectors are exercised only when DIV_SIGNED_EN is defined.
module tb_seq_divider_32;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [31:0] dividend = '0;
   logic [31:0] divisor = '0;
   logic        busy;
   logic        done;
   logic [31:0] quotient;
   logic [31:0] remainder;
   logic        div_by_zero;

   int vectors = 0;
   int miscompares = 0;

   seq_divider_32 #(.WIDTH(32), .CNT_W(6)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
      end
   endtask

   // Accepts one division, scrambles the operand inputs, and returns the number of
   // edges from the accept edge until done is seen (-1 if it never arrives).
   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, output int edges);
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start    = 1'b0;
      dividend = 32'hDEAD_BEEF;
      divisor  = 32'h0000_0003;
      edges    = -1;
      for (int i = 1; i <= 100; i++) begin
         @(posedge clk);
         #1;
         if (done) begin
            edges = i;
            break;
         end
      end
   endtask

   task automatic checkResult(input string tag, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] exp_q, input logic [31:0] exp_r,
                              input logic exp_dbz, input int exp_edges);
      int edges;
      applyStimulus(a, b, edges);
      checkOutput({tag, "_latency"}, 32'(edges), 32'(exp_edges));
      checkOutput({tag, "_quotient"}, quotient, exp_q);
      checkOutput({tag, "_remainder"}, remainder, exp_r);
      checkOutput({tag, "_dbz"}, {31'b0, div_by_zero}, {31'b0, exp_dbz});
      checkOutput({tag, "_busy_at_done"}, {31'b0, busy}, 32'd0);
   endtask

   initial begin
      int edges;
      int spurious;

      #12;
      checkOutput("reset_busy", {31'b0, busy}, 32'd0);
      checkOutput("reset_done", {31'b0, done}, 32'd0);
      checkOutput("reset_quotient", quotient, 32'd0);
      checkOutput("reset_remainder", remainder, 32'd0);
      checkOutput("reset_dbz", {31'b0, div_by_zero}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Load results, then abort a later division mid-RUN.
      checkResult("div_100_7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33);
      dividend = 32'd5000;
      divisor  = 32'd3;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      checkOutput("midrun_busy", {31'b0, busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      checkOutput("abort_busy", {31'b0, busy}, 32'd0);
      checkOutput("abort_done", {31'b0, done}, 32'd0);
      checkOutput("abort_quotient", quotient, 32'd0);
      checkOutput("abort_remainder", remainder, 32'd0);
      checkOutput("abort_dbz", {31'b0, div_by_zero}, 32'd0);
      #7;
      rst_n = 1'b1;
      spurious = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (done) spurious++;
      end
      checkOutput("no_spurious_done", 32'(spurious), 32'd0);

      checkResult("div_max_1", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 33);
      checkResult("div_by_zero", 32'd1234, 32'd0, 32'hFFFF_FFFF, 32'd1234, 1'b1, 1);
      checkResult("div_5_9", 32'd5, 32'd9, 32'd0, 32'd5, 1'b0, 33);

      // A start pulse during RUN must neither disturb the result nor queue a second op.
      dividend = 32'd1000;
      divisor  = 32'd10;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      dividend = 32'd77;
      divisor  = 32'd3;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      edges = -1;
      for (int i = 1; i <= 100; i++) begin
         @(posedge clk);
         #1;
         if (done) begin
            edges = i + 6;
            break;
         end
      end
      checkOutput("ignore_latency", 32'(edges), 32'd33);
      checkOutput("ignore_quotient", quotient, 32'd100);
      checkOutput("ignore_remainder", remainder, 32'd0);
      @(posedge clk);
      #1;
      checkOutput("ignore_not_queued", {31'b0, busy}, 32'd0);

      // Start held high: the next division is accepted on the edge closing the done cycle.
      dividend = 32'd50;
      divisor  = 32'd6;
      start    = 1'b1;
      edges = -1;
      for (int i = 1; i <= 100; i++) begin
         @(posedge clk);
         #1;
         if (done) begin
            edges = i;
            break;
         end
      end
      checkOutput("held_first_latency", 32'(edges), 32'd34);
      checkOutput("held_first_quotient", quotient, 32'd8);
      @(posedge clk);
      #1;
      checkOutput("held_restart_busy", {31'b0, busy}, 32'd1);
      edges = -1;
      for (int i = 2; i <= 100; i++) begin
         @(posedge clk);
         #1;
         if (done) begin
            edges = i;
            break;
         end
      end
      start = 1'b0;
      checkOutput("held_throughput", 32'(edges), 32'd34);
      checkOutput("held_second_remainder", remainder, 32'd2);
      @(posedge clk);
      #1;

`ifdef DIV_SIGNED_EN
      checkResult("s_neg7_2", 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 33);
      checkResult("s_7_neg2", 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 33);
      checkResult("s_min_neg1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 33);
      checkResult("s_neg9_zero", 32'hFFFF_FFF7, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF7, 1'b1, 1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
